// File: rtl/period_serial_loader.sv
// Serial period loader: synchronises a 3-wire port, deserialises MSB-first,
// validates the frame and strobes the period word into the counter.
module period_serial_loader #(
  parameter int BITS        = 12,
  parameter int MIN_PERIOD  = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ser_clk,
  input  logic            ser_data,
  input  logic            ser_cs_n,
  output logic [BITS-1:0] period,
  output logic            period_load,
  output logic            frame_error,
  output logic            busy
);

  localparam int CW = $clog2(BITS + 2);

  localparam logic [CW-1:0]   CNT_FULL = CW'(BITS);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(BITS + 1);
  localparam logic [BITS-1:0] MIN_P    = BITS'(MIN_PERIOD);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_s;
  logic [SYNC_STAGES-1:0] data_s;
  logic [SYNC_STAGES-1:0] cs_s;

  logic sclk_h1, sclk_h2;
  logic cs_h1, cs_h2;
  logic data_h;

  logic sclk_rise_q;
  logic cs_fall_q;
  logic cs_rise_q;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] sr;

  logic sclk_rise_c;
  logic cs_fall_c;
  logic cs_rise_c;

  assign sclk_rise_c = sclk_h1 & ~sclk_h2;
  assign cs_fall_c   = ~cs_h1 & cs_h2;
  assign cs_rise_c   = cs_h1 & ~cs_h2;

  assign busy = (state != IDLE);

  // Synchronisers, history flops and registered edge flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s      <= '0;
      data_s      <= '0;
      cs_s        <= '1;
      sclk_h1     <= 1'b0;
      sclk_h2     <= 1'b0;
      cs_h1       <= 1'b1;
      cs_h2       <= 1'b1;
      data_h      <= 1'b0;
      sclk_rise_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      sclk_s      <= {sclk_s[SYNC_STAGES-2:0], ser_clk};
      data_s      <= {data_s[SYNC_STAGES-2:0], ser_data};
      cs_s        <= {cs_s[SYNC_STAGES-2:0], ser_cs_n};
      sclk_h1     <= sclk_s[SYNC_STAGES-1];
      sclk_h2     <= sclk_h1;
      cs_h1       <= cs_s[SYNC_STAGES-1];
      cs_h2       <= cs_h1;
      data_h      <= data_s[SYNC_STAGES-1];
      sclk_rise_q <= sclk_rise_c;
      cs_rise_q   <= cs_rise_c;
      // A fall seen during COMMIT is held so IDLE picks it up next cycle.
      cs_fall_q   <= cs_fall_c | (cs_fall_q & (state == COMMIT));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      period      <= '0;
      period_load <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      period_load <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall_q) begin
            state <= SHIFT;
            cnt   <= '0;
            sr    <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise_q) begin
            state <= COMMIT;
          end else if (sclk_rise_q) begin
            sr <= {sr[BITS-2:0], data_h};
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (cnt == CNT_FULL && sr >= MIN_P) begin
            period      <= sr;
            period_load <= 1'b1;
          end else if (cnt != '0) begin
            frame_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
